// File: rtl/microcode_sequencer.sv
// Microcode ROM walker: fetches and decodes one program from address 0 and
// issues one gate command per word to the gate engine over valid/ready.
module microcode_sequencer #(
  parameter int NQ_MAX = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        prog_id_in,
  input  logic [2:0]        n_qubits,
  output logic [2:0]        rom_prog_id,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              gate_valid,
  input  logic              gate_ready,
  output logic [3:0]        gate_op,
  output logic [3:0]        gate_qa,
  output logic [3:0]        gate_qb,
  output logic [7:0]        gate_angle,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [7:0]        instr_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    DONE,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic [2:0]  nq_r;

  logic [3:0]  op;
  logic [3:0]  qa;
  logic [3:0]  qb;
  logic [7:0]  p1;
  logic        is_illegal;
  logic        is_end;
  logic        is_nop;
  logic        range_err;
  logic        mask_bad;
  logic        last_addr;
  logic        unused_bits;

  always_comb begin
    op          = ir[31:28];
    qa          = ir[27:24];
    qb          = ir[23:20];
    p1          = ir[11:4];
    unused_bits = ^{ir[19:12], ir[3:0]};
    is_illegal  = (op >= 4'd8) && (op <= 4'd14);
    is_end      = (op == 4'd15);
    is_nop      = (op == 4'd0);
    last_addr   = (rom_addr == '1);
    mask_bad    = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (qa[i] && (i >= 32'(nq_r))) mask_bad = 1'b1;
    end
    range_err = 1'b0;
    if ((op >= 4'd1) && (op <= 4'd6) && (qa >= {1'b0, nq_r})) range_err = 1'b1;
    if ((op >= 4'd4) && (op <= 4'd6) && ((qb >= {1'b0, nq_r}) || (qb == qa))) range_err = 1'b1;
    if ((op == 4'd7) && mask_bad) range_err = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ir          <= '0;
      nq_r        <= '0;
      rom_prog_id <= '0;
      rom_addr    <= '0;
      gate_valid  <= 1'b0;
      gate_op     <= '0;
      gate_qa     <= '0;
      gate_qb     <= '0;
      gate_angle  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      instr_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rom_prog_id <= prog_id_in;
            // Counts above the supported maximum are clamped so range checks stay meaningful.
            nq_r        <= (32'(n_qubits) > NQ_MAX) ? 3'(NQ_MAX) : n_qubits;
            rom_addr    <= '0;
            instr_count <= '0;
            err         <= 1'b0;
            err_code    <= '0;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          ir    <= rom_data;
          state <= DECODE;
        end
        DECODE: begin
          if (is_illegal) begin
            err_code <= 2'd2;
            err      <= 1'b1;
            state    <= HALT;
          end else if (is_end) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (is_nop) begin
            if (last_addr) begin
              err_code <= 2'd3;
              err      <= 1'b1;
              state    <= HALT;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= FETCH;
            end
          end else if (range_err) begin
            err_code <= 2'd1;
            err      <= 1'b1;
            state    <= HALT;
          end else begin
            gate_op    <= op;
            gate_qa    <= qa;
            gate_qb    <= qb;
            gate_angle <= p1;
            gate_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (gate_ready) begin
            gate_valid <= 1'b0;
            if (instr_count != '1) instr_count <= instr_count + 1'b1;
            if (last_addr) begin
              err_code <= 2'd3;
              err      <= 1'b1;
              state    <= HALT;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        HALT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
